vanilla_exe_bubble_profiler_ctrl: RTL and testbench

Per-core profiling controller that turns the EXE-stage bubble classification stream into a bank of per-type cycle counters, plus a total-cycle counter. It sequences a read-and-clear dump of that bank over a valid/ready stream when software or the testbench host requests one. It sits in the testbench profiler path directly downstream of the EXE bubble classifier's `exe_bubble_type_o`.

---
 rtl/vanilla_exe_bubble_profiler_ctrl.sv | 111 +++++++++++
 tb/tb_vanilla_exe_bubble_profiler_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_exe_bubble_profiler_ctrl.sv
// EXE bubble profiler: saturating per-type counters plus a total-cycle counter.
// A read-and-clear dump streams the counters out over a valid/ready port.

module vanilla_exe_bubble_profiler_ctrl_cnt #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               inc,
    input  logic               clr,
    output logic [width_p-1:0] count
);
    // A clear wins over the old value but keeps the increment from the same cycle
    always_ff @(posedge clk_i) begin
        if (!reset_n_i)                  count <= '0;
        else if (clr)                    count <= inc ? width_p'(1) : '0;
        else if (inc && (count != '1))   count <= count + width_p'(1);
    end
endmodule

module vanilla_exe_bubble_profiler_ctrl #(
    parameter int num_types_p     = 32,
    parameter int counter_width_p = 32,
    parameter int idx_width_p     = $clog2(num_types_p+1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic [31:0]                exe_bubble_type_i,
    input  logic                       dump_start_i,
    output logic                       busy_o,
    output logic                       dump_v_o,
    input  logic                       dump_ready_i,
    output logic [idx_width_p-1:0]     dump_idx_o,
    output logic [counter_width_p-1:0] dump_count_o,
    output logic                       dump_last_o,
    output logic                       bad_type_o
);
    typedef enum logic {IDLE, DUMP} state_e;

    state_e                                    state_q, state_d;
    logic [idx_width_p-1:0]                    idx_q, idx_d;
    logic [num_types_p:0][counter_width_p-1:0] cnt;
    logic [num_types_p:0]                      inc, clr;
    logic                                      type_ok, hs, is_last;

    assign type_ok = exe_bubble_type_i < 32'(num_types_p);
    assign hs      = dump_v_o & dump_ready_i;
    assign is_last = idx_q == idx_width_p'(num_types_p);

    // Slot num_types_p is the total-cycle counter
    for (genvar g = 0; g <= num_types_p; g++) begin : g_cnt
        if (g == num_types_p) begin : g_total
            assign inc[g] = en_i;
        end else begin : g_type
            assign inc[g] = en_i & (exe_bubble_type_i == 32'(g));
        end
        assign clr[g] = hs & (idx_q == idx_width_p'(g));

        vanilla_exe_bubble_profiler_ctrl_cnt #(.width_p(counter_width_p)) u_cnt (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .inc       (inc[g]),
            .clr       (clr[g]),
            .count     (cnt[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            bad_type_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            if (en_i && !type_ok) bad_type_o <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (dump_start_i) begin
                state_d = DUMP;
                idx_d   = '0;
            end
            DUMP: if (dump_ready_i) begin
                if (is_last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + idx_width_p'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dump_count_o = '0;
        for (int i = 0; i <= num_types_p; i++)
            if (idx_q == idx_width_p'(i)) dump_count_o = cnt[i];
    end

    assign busy_o      = (state_q == DUMP);
    assign dump_v_o    = busy_o;
    assign dump_idx_o  = idx_q;
    assign dump_last_o = busy_o & is_last;
endmodule

// File: tb/tb_vanilla_exe_bubble_profiler_ctrl.sv
// Bench for the bubble profiler: directed scenarios then random traffic, with
// a 32-bit and a 4-bit counter instance checked against a cycle model.
module tb_vanilla_exe_bubble_profiler_ctrl;
    localparam int NT = 32;

    logic        clk = 1'b0;
    logic        rst_n, en, start, ready;
    logic [31:0] btype;

    logic        busy32, v32, last32, bad32;
    logic [5:0]  idx32;
    logic [31:0] cnt32;
    logic        busy4, v4, last4, bad4;
    logic [5:0]  idx4;
    logic [3:0]  cnt4;

    vanilla_exe_bubble_profiler_ctrl dut32 (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .exe_bubble_type_i(btype),
        .dump_start_i(start), .busy_o(busy32), .dump_v_o(v32), .dump_ready_i(ready),
        .dump_idx_o(idx32), .dump_count_o(cnt32), .dump_last_o(last32), .bad_type_o(bad32));

    vanilla_exe_bubble_profiler_ctrl #(.counter_width_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .exe_bubble_type_i(btype),
        .dump_start_i(start), .busy_o(busy4), .dump_v_o(v4), .dump_ready_i(ready),
        .dump_idx_o(idx4), .dump_count_o(cnt4), .dump_last_o(last4), .bad_type_o(bad4));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: counters indexed 0..NT, slot NT is the enabled-cycle total
    longint mc32 [NT+1];
    longint mc4  [NT+1];
    bit     mbusy = 0;
    int     midx  = 0;
    bit     mbad  = 0;
    longint cap32 [NT+1];
    longint cap4  [NT+1];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit hs;
        hs = rst_n && mbusy && ready;
        if (hs) begin
            cap32[midx] = longint'(cnt32);
            cap4[midx]  = longint'(cnt4);
        end
        if (!rst_n) begin
            foreach (mc32[i]) begin mc32[i] = 0; mc4[i] = 0; end
            mbusy = 0; midx = 0; mbad = 0;
        end else begin
            for (int i = 0; i <= NT; i++) begin
                bit hit, clear;
                hit   = en && ((i == NT) || (longint'(btype) == longint'(i)));
                clear = hs && (midx == i);
                if (clear) begin
                    mc32[i] = hit ? 1 : 0;
                    mc4[i]  = hit ? 1 : 0;
                end else if (hit) begin
                    if (mc32[i] < 64'hFFFF_FFFF) mc32[i]++;
                    if (mc4[i]  < 15)            mc4[i]++;
                end
            end
            if (en && btype >= 32'(NT)) mbad = 1;
            if (!mbusy) begin
                if (start) begin mbusy = 1; midx = 0; end
            end else if (hs) begin
                if (midx == NT) begin mbusy = 0; midx = 0; end
                else midx++;
            end
        end
        @(posedge clk); #1;
        chk("busy32", longint'(busy32), longint'(mbusy));
        chk("v32",    longint'(v32),    longint'(mbusy));
        chk("busy4",  longint'(busy4),  longint'(mbusy));
        chk("bad32",  longint'(bad32),  longint'(mbad));
        chk("bad4",   longint'(bad4),   longint'(mbad));
        if (mbusy) begin
            chk("idx32",   longint'(idx32),  longint'(midx));
            chk("idx4",    longint'(idx4),   longint'(midx));
            chk("count32", longint'(cnt32),  mc32[midx]);
            chk("count4",  longint'(cnt4),   mc4[midx]);
            chk("last32",  longint'(last32), longint'(midx == NT));
        end
    endtask

    task automatic do_reset();
        rst_n = 0; step(); rst_n = 1;
    endtask

    // Start a dump and drain it with ready high; bounded so a stuck DUT cannot hang
    task automatic dump_all();
        int guard;
        start = 1; step(); start = 0; ready = 1;
        guard = 0;
        while (mbusy && guard < 200) begin step(); guard++; end
        chk("dump_done", longint'(mbusy), 0);
    endtask

    initial begin
        rst_n = 0; en = 0; start = 0; ready = 1; btype = 0;
        foreach (mc32[i]) begin mc32[i] = 0; mc4[i] = 0; cap32[i] = -1; cap4[i] = -1; end

        // Reset state
        do_reset();
        chk("rst_busy", longint'(busy32), 0);
        chk("rst_v",    longint'(v32), 0);
        chk("rst_idx",  longint'(idx32), 0);
        chk("rst_cnt",  longint'(cnt32), 0);
        chk("rst_last", longint'(last32), 0);
        chk("rst_bad",  longint'(bad32), 0);

        // Basic counts
        en = 1; btype = 3;
        repeat (10) step();
        btype = 0;
        repeat (5) step();
        en = 0;
        dump_all();
        chk("basic_idx0",  cap32[0], 5);
        chk("basic_idx3",  cap32[3], 10);
        chk("basic_idx5",  cap32[5], 0);
        chk("basic_total", cap32[NT], 15);
        chk("basic_idle",  longint'(busy32), 0);

        // Backpressure at idx 3
        en = 1; btype = 3; repeat (6) step(); en = 0;
        start = 1; step(); start = 0; ready = 1;
        while (midx != 3) step();
        ready = 0;
        repeat (4) begin
            step();
            chk("bp_idx", longint'(idx32), 3);
            chk("bp_cnt", longint'(cnt32), 6);
            chk("bp_v",   longint'(v32), 1);
        end
        ready = 1; step();
        chk("bp_adv", longint'(idx32), 4);
        while (mbusy) step();

        // Clear with concurrent increment at idx 7
        do_reset();
        en = 1; btype = 7;
        repeat (12) step();
        start = 1; step(); start = 0; ready = 1;
        while (!(mbusy && midx == 7)) step();
        chk("clr_pre", longint'(cnt32), 20);
        step();
        en = 0;
        while (mbusy) step();
        chk("clr_word", cap32[7], 20);
        dump_all();
        chk("clr_after", cap32[7], 1);

        // Saturation on the 4-bit instance
        do_reset();
        en = 1; btype = 2; repeat (20) step(); en = 0;
        dump_all();
        chk("sat_idx2",  cap4[2], 15);
        chk("sat_total", cap4[NT], 15);
        chk("nosat32",   cap32[2], 20);

        // Bad type code
        do_reset();
        en = 1; btype = 40; repeat (3) step(); en = 0;
        chk("bad_set", longint'(bad32), 1);
        dump_all();
        chk("bad_t0",    cap32[0], 0);
        chk("bad_total", cap32[NT], 3);
        chk("bad_stick", longint'(bad32), 1);
        do_reset();
        chk("bad_clr", longint'(bad32), 0);

        // Start ignored while busy, then reset mid-dump
        en = 1; btype = 4; repeat (8) step(); en = 0;
        start = 1; step(); start = 0; ready = 1;
        while (midx != 5) step();
        start = 1; step(); start = 0;
        chk("norestart", longint'(idx32), 6);
        while (midx != 9) step();
        do_reset();
        chk("mid_busy", longint'(busy32), 0);
        chk("mid_v",    longint'(v32), 0);
        en = 1; btype = 4; repeat (2) step(); en = 0;
        dump_all();
        chk("mid_t4",    cap32[4], 2);
        chk("mid_total", cap32[NT], 2);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            en    = ($urandom_range(0, 3) != 0);
            btype = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NT + 1));
            start = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1; start = 0; en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
